uart_mem_ctrl: RTL and testbench

UART_MEM_CTRL -- requirements
Module: uart_mem_ctrl

---
 rtl/uart_mem_ctrl_pkg.sv | 31 +++
 rtl/uart_mem_ctrl_rr_arb.sv | 37 +++
 rtl/uart_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_ctrl_pkg.sv
// rtl/uart_mem_ctrl_pkg.sv - shared constants and types for the UART memory bridge
//
// Purpose: state encodings, header bit positions and the header builder used by
//          uart_mem_ctrl.
// Ports:   none (package).
package uart_mem_ctrl_pkg;

  // Controller states. Encodings are fixed so debug taps stay stable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RPOP  = 3'd4,
    ST_RCAP  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Header byte layout: {we, port, 6'b0}.
  localparam int HDR_WE_BIT   = 7;
  localparam int HDR_PORT_BIT = 6;

  function automatic logic [7:0] make_hdr(input logic we, input logic port);
    logic [7:0] h;
    h               = 8'h00;
    h[HDR_WE_BIT]   = we;
    h[HDR_PORT_BIT] = port;
    return h;
  endfunction

endpackage

// File: rtl/uart_mem_ctrl_rr_arb.sv
// rtl/uart_mem_ctrl_rr_arb.sv - two-port round-robin arbiter
//
// Purpose: one-hot grant between two requesters; on a tie the port not served
//          last wins. After reset p1 counts as last served, so p0 wins first.
// Ports:   clk, rst     - clock, async active-high reset
//          req[1:0]     - request per port
//          advance      - grant is being consumed this cycle
//          grant[1:0]   - one-hot grant (combinational from req)
module uart_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_p1;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_p1 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_p1 <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_p1 <= grant[1];
    end
  end

endmodule

// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - two-port memory access bridged over a byte UART
//
// Purpose: serialises p0/p1 memory accesses into UART bytes
//          (header, address LSB first, write data LSB first) and, for reads,
//          collects WORD_BYTES response bytes from the UART receive queue.
// Ports:   clk, rst                     - clock, async active-high reset
//          pN_req/we/addr/wdata         - requester n access (held until pN_ready)
//          pN_rdata, pN_ready           - read result / one-cycle completion
//          send_flag, send_data         - push to UART transmit queue
//          sendable                     - transmit queue not full
//          recv_flag, recv_data         - pop from UART receive queue
//          receivable                   - receive queue not empty
//          busy                         - controller not idle
module uart_mem_ctrl
  import uart_mem_ctrl_pkg::*;
#(
  parameter int ADDR_BYTES = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        send_flag,
  output logic [7:0]  send_data,
  input  logic        sendable,
  output logic        recv_flag,
  input  logic [7:0]  recv_data,
  input  logic        receivable,
  output logic        busy
);

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);

  state_t      state, state_nx;
  logic [1:0]  grant;
  logic        advance;
  logic [1:0]  cnt;       // byte index within ADDR / WDATA
  logic [1:0]  rx_idx;    // byte index across the RPOP/RCAP loop
  logic        gap;       // a push happened last cycle; sendable may be stale
  logic        port_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rx_buf;
  logic [31:0] rx_word;
  logic        push_state;

  assign advance = (state == ST_IDLE);

  uart_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_req, p0_req}),
    .advance (advance),
    .grant   (grant)
  );

  assign push_state = (state == ST_HDR) || (state == ST_ADDR) || (state == ST_WDATA);
  assign send_flag  = push_state && sendable && !gap;
  assign recv_flag  = (state == ST_RPOP) && receivable;
  assign busy       = (state != ST_IDLE);
  assign p0_ready   = (state == ST_DONE) && !port_q;
  assign p1_ready   = (state == ST_DONE) && port_q;

  always_comb begin
    send_data = 8'h00;
    case (state)
      ST_HDR:   send_data = make_hdr(we_q, port_q);
      ST_ADDR:  send_data = addr_q[{cnt, 3'b000} +: 8];
      ST_WDATA: send_data = wdata_q[{cnt, 3'b000} +: 8];
      default:  send_data = 8'h00;
    endcase
  end

  // Word as it will look once the byte arriving in this RCAP is merged in.
  always_comb begin
    rx_word = rx_buf;
    rx_word[{rx_idx, 3'b000} +: 8] = recv_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant != 2'b00) state_nx = ST_HDR;
      ST_HDR:   if (send_flag) state_nx = ST_ADDR;
      ST_ADDR:  if (send_flag && (cnt == ADDR_LAST)) state_nx = we_q ? ST_WDATA : ST_RPOP;
      ST_WDATA: if (send_flag && (cnt == WORD_LAST)) state_nx = ST_DONE;
      ST_RPOP:  if (receivable) state_nx = ST_RCAP;
      ST_RCAP:  state_nx = (rx_idx == WORD_LAST) ? ST_DONE : ST_RPOP;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
      gap   <= 1'b0;
    end else begin
      state <= state_nx;
      gap   <= send_flag;
      if (state_nx != state) begin
        cnt <= 2'd0;
      end else if (send_flag) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rx_buf   <= 32'h0;
      rx_idx   <= 2'd0;
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
    end else begin
      if ((state == ST_IDLE) && (grant != 2'b00)) begin
        port_q  <= grant[1];
        we_q    <= grant[1] ? p1_we    : p0_we;
        addr_q  <= grant[1] ? p1_addr  : p0_addr;
        wdata_q <= grant[1] ? p1_wdata : p0_wdata;
        rx_buf  <= 32'h0;
        rx_idx  <= 2'd0;
      end
      if (state == ST_RCAP) begin
        rx_buf <= rx_word;
        rx_idx <= rx_idx + 2'd1;
        // Publish on the last capture so rdata is already valid in DONE.
        if (rx_idx == WORD_LAST) begin
          if (port_q) p1_rdata <= rx_word;
          else        p0_rdata <= rx_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb/tb_uart_mem_ctrl.sv - scoreboard bench for uart_mem_ctrl
module tb_uart_mem_ctrl;

  localparam int AB = 4;
  localparam int WB = 4;

  logic        clk, rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic        send_flag, sendable, recv_flag, receivable, busy;
  logic [7:0]  send_data, recv_data;

  uart_mem_ctrl #(.ADDR_BYTES(AB), .WORD_BYTES(WB)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] rdata;
  } cpl_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_tx[$];
  cpl_t        exp_cpl[$];
  logic [7:0]  rxq[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] held[2];
  logic        rr_last = 1'b1;
  int          tx_mode = 1;
  int          rx_mode = 1;
  int          cyc = 0;
  int          pops_req = 0;
  int          pops_done = 0;
  int          rf_count = 0;
  int          tx_count = 0;
  int          last_rf = -10;
  logic        prev_send = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a word memory behind the UART. Expected byte stream and
  // completions are derived from the grant order the round-robin rule implies.
  task automatic model_issue(input logic [1:0] mask, input logic [1:0] we,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] av[2];
    logic [31:0] dv[2];
    logic [31:0] wmask;
    logic [31:0] data;
    int          order[$];
    cpl_t        c;
    av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
    wmask = (WB == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * WB)) - 32'h1);
    if (mask == 2'b11) order = rr_last ? '{0, 1} : '{1, 0};
    else               order = mask[1] ? '{1} : '{0};
    foreach (order[i]) begin
      int p;
      p = order[i];
      rr_last = 1'(p);
      exp_tx.push_back({we[p], 1'(p), 6'b000000});
      for (int b = 0; b < AB; b++) exp_tx.push_back(av[p][8*b +: 8]);
      c.port = 1'(p);
      c.we   = we[p];
      c.rdata = 32'h0;
      if (we[p]) begin
        for (int b = 0; b < WB; b++) exp_tx.push_back(dv[p][8*b +: 8]);
        mem[av[p]] = dv[p] & wmask;
      end else begin
        if (!mem.exists(av[p])) mem[av[p]] = $urandom & wmask;
        data = mem[av[p]];
        for (int b = 0; b < WB; b++) rxq.push_back(data[8*b +: 8]);
        c.rdata = data;
      end
      exp_cpl.push_back(c);
    end
  endtask

  // UART-side environment: flow control and the receive queue's data register.
  logic rx_gate;
  initial begin
    sendable = 1'b0; receivable = 1'b0; recv_data = 8'h00; rx_gate = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      while (pops_done < pops_req) begin
        if (rxq.size() > 0) recv_data = rxq.pop_front();
        pops_done++;
      end
      case (tx_mode)
        0:       sendable = ($urandom_range(0, 3) != 0);
        1:       sendable = 1'b1;
        default: sendable = 1'b0;
      endcase
      case (rx_mode)
        0:       rx_gate = ($urandom_range(0, 2) != 0);
        1:       rx_gate = 1'b1;
        default: rx_gate = (((cyc / 3) % 2) == 1);
      endcase
      receivable = rx_gate && (rxq.size() > 0);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (send_flag) begin
        tx_count++;
        chk("send_needs_sendable", 32'(sendable), 32'h1);
        chk("send_gap", 32'(prev_send), 32'h0);
        if (exp_tx.size() == 0) chk("tx_extra", 32'(send_data), 32'hFFFF_FFFF);
        else                    chk("tx_byte", 32'(send_data), 32'(exp_tx.pop_front()));
      end
      prev_send = send_flag;
      if (recv_flag) begin
        rf_count++;
        chk("recv_needs_receivable", 32'(receivable), 32'h1);
        chk("recv_spacing_ok", 32'((cyc - last_rf) >= 2), 32'h1);
        last_rf = cyc;
        pops_req++;
      end
      if (p0_ready || p1_ready) begin
        int   p;
        cpl_t c;
        p = p1_ready ? 1 : 0;
        chk("ready_onehot", 32'(p0_ready && p1_ready), 32'h0);
        if (exp_cpl.size() == 0) begin
          chk("ready_extra", 32'(p), 32'hFFFF_FFFF);
        end else begin
          c = exp_cpl.pop_front();
          chk("ready_port", 32'(p), 32'(c.port));
          if (!c.we) begin
            chk("rdata", p ? p1_rdata : p0_rdata, c.rdata);
            held[p] = c.rdata;
          end
          chk("rdata_other_held", p ? p0_rdata : p1_rdata, held[1-p]);
        end
      end
    end else begin
      prev_send = 1'b0;
    end
  end

  task automatic wait_ready(input int p);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    while (!got && n < 3000) begin
      @(negedge clk);
      #1;
      got = p ? p1_ready : p0_ready;
      n++;
    end
    if (!got) chk("ready_timeout", 32'(p), 32'hFFFF_FFFF);
  endtask

  task automatic run_round(input logic [1:0] mask, input logic [1:0] we,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic early);
    model_issue(mask, we, a0, a1, d0, d1);
    @(posedge clk);
    #2;
    p0_we = we[0]; p0_addr = a0; p0_wdata = d0; p0_req = mask[0];
    p1_we = we[1]; p1_addr = a1; p1_wdata = d1; p1_req = mask[1];
    fork
      begin
        if (mask[0]) begin
          if (early) begin
            repeat (3) @(negedge clk);
            #1;
            p0_req = 1'b0; p0_we = ~p0_we; p0_addr = $urandom; p0_wdata = $urandom;
          end
          wait_ready(0);
          p0_req = 1'b0;
        end
      end
      begin
        if (mask[1]) begin
          if (early) begin
            repeat (3) @(negedge clk);
            #1;
            p1_req = 1'b0; p1_we = ~p1_we; p1_addr = $urandom; p1_wdata = $urandom;
          end
          wait_ready(1);
          p1_req = 1'b0;
        end
      end
    join
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_send_flag", 32'(send_flag), 32'h0);
    chk("rst_recv_flag", 32'(recv_flag), 32'h0);
    chk("rst_send_data", 32'(send_data), 32'h0);
    chk("rst_p0_ready", 32'(p0_ready), 32'h0);
    chk("rst_p1_ready", 32'(p1_ready), 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
  endtask

  task automatic stall_mid_address();
    logic [31:0] a, d;
    int          s0, n;
    a = $urandom; d = $urandom;
    tx_mode = 1; rx_mode = 1;
    model_issue(2'b01, 2'b01, a, 32'h0, d, 32'h0);
    s0 = tx_count;
    @(posedge clk);
    #2;
    p0_we = 1'b1; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
    n = 0;
    while (tx_count < s0 + 2 && n < 200) begin @(negedge clk); #1; n++; end
    if (tx_count < s0 + 2) chk("stall_setup_timeout", 32'(tx_count), 32'(s0 + 2));
    tx_mode = 2;
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("stall_send_flag", 32'(send_flag), 32'h0);
      chk("stall_send_data", 32'(send_data), 32'(a[15:8]));
    end
    tx_mode = 1;
    wait_ready(0);
    p0_req = 1'b0;
  endtask

  task automatic reset_mid_read(input logic [31:0] a);
    int s0, n;
    tx_mode = 1; rx_mode = 1;
    model_issue(2'b01, 2'b00, a, 32'h0, 32'h0, 32'h0);
    s0 = rf_count;
    @(posedge clk);
    #2;
    p0_we = 1'b0; p0_addr = a; p0_req = 1'b1;
    n = 0;
    while (rf_count < s0 + 2 && n < 300) begin @(negedge clk); #1; n++; end
    if (rf_count < s0 + 2) chk("rcap_wait_timeout", 32'(rf_count), 32'(s0 + 2));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    p0_req = 1'b0;
    exp_tx.delete();
    exp_cpl.delete();
    rxq.delete();
    held[0] = 32'h0; held[1] = 32'h0;
    rr_last = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    held[0] = 32'h0; held[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Tie right after reset: p0 first, then p1.
    run_round(2'b11, 2'b10, 32'h20, 32'h24, 32'h0, 32'hCAFE_0001, 1'b0);
    mem[32'h1234] = 32'h1234_5678;
    run_round(2'b01, 2'b00, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0);
    run_round(2'b10, 2'b10, 32'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) run_round(2'b11, 2'b00, 32'h10, 32'h1234, 32'h0, 32'h0, 1'b0);

    stall_mid_address();

    run_round(2'b10, 2'b00, 32'h0, 32'h10, 32'h0, 32'h0, 1'b1);
    run_round(2'b01, 2'b01, 32'h30, 32'h0, 32'h5555_AAAA, 32'h0, 1'b1);

    reset_mid_read(32'h40);
    run_round(2'b11, 2'b00, 32'h40, 32'h30, 32'h0, 32'h0, 1'b0);

    rx_mode = 2; tx_mode = 1;
    for (int i = 0; i < 3; i++) run_round(2'b11, 2'b00, 32'h40, 32'h1234, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] m, w;
      m = 2'($urandom_range(1, 3));
      w = 2'($urandom_range(0, 3));
      tx_mode = $urandom_range(0, 1);
      rx_mode = $urandom_range(0, 2);
      run_round(m, w, {27'h0, 3'($urandom_range(0, 7)), 2'b00},
                {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, $urandom, 1'b0);
    end

    repeat (5) @(negedge clk);
    #1;
    chk("tx_drained", 32'(exp_tx.size()), 32'h0);
    chk("cpl_drained", 32'(exp_cpl.size()), 32'h0);
    chk("idle_at_end", 32'(busy), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
